codec_config_sequencer: RTL and testbench
=========================================

# codec_config_sequencer

Upstream configuration master for the audio codec's I2C write engine. After reset (or on request) it walks a fixed table of codec register writes, presents each 24-bit word `{slave addr, sub addr, data}` to the I2C controller, and drives its GO/END handshake. It checks ACK, retries NACKed words and flags persistent failure. It also generates the slow controller clock, so the controller's whole clock domain is owned here.

## Interface
- `CLK_DIV`, 1250: `CLOCK` cycles per `CTRL_CLK` half-period (50 MHz gives 20 kHz `CTRL_CLK`); minimum 2.
- `SLAVE_ADDR`, 8'h34: codec write address, upper byte of every word.
- `NUM_REGS`, 8: table entries to send.
- `MAX_RETRY`, 3: extra attempts per word after a failure.
- `TO_START`, 4: `CTRL_CLK` periods allowed for END to fall after GO rises.
- `TO_END`, 40: `CTRL_CLK` periods allowed for END to rise after it fell.

Ports:
- `CLOCK` in 1: system clock.
- `RESET` in 1: asynchronous, active-low reset.
- `START` in 1: rerun request, sampled on `CLOCK`, level or pulse.
- `CTRL_CLK` out 1: divided clock for the I2C controller.
- `I2C_DATA` out 24: word to the controller.
- `GO` out 1: transaction request to the controller.
- `END` in 1: controller done flag; 1 while idle.
- `ACK` in 1: controller NACK flag; 1 means a NACK occurred.
- `BUSY` out 1: table sequence in progress.
- `DONE` out 1: all words ACKed; held until next run.
- `ERROR` out 1: retry budget exhausted; held until next run.
- `IDX` out 4: current table index, for debug.

## Operation
- Divider: counter 0..`CLK_DIV`-1. At terminal count, toggle `CTRL_CLK`. A tick occurs on the terminal count where `CTRL_CLK` goes 1→0 (the falling tick). The FSM advances only on falling ticks.
- Table words: 0x1E00 (reset), 0x0C00 (power all on), 0x0E42 (master, I2S, 16-bit), 0x1000 (48 kHz normal), 0x0812 (DAC select, mic mute), 0x0A00 (DAC unmute), 0x0579 (headphone 0 dB, both channels), 0x1201 (active).
- `I2C_DATA` = `{SLAVE_ADDR, table[IDX]}`.
- FSM states (advancing on falling ticks):
  - IDLE: on the first tick after reset release, auto-start. Clear `IDX`, retry count, `DONE` and `ERROR`; go to ARM.
  - ARM: `GO`=1, `I2C_DATA` loaded. Wait for `END`=0, then go to WAIT_END. If `TO_START` ticks pass first, it is a failure.
  - WAIT_END: wait for `END`=1, then go to CHECK. If `TO_END` ticks pass first, it is a failure.
  - CHECK: if `ACK`=0, the word succeeded. Otherwise it is a failure.
  - GAP: `GO`=0 for exactly one tick. Then:
    - if the last word succeeded and it was word `NUM_REGS`-1, go to FIN;
    - if it succeeded otherwise, increment `IDX`, reset the retry count, go to ARM;
    - after a failure, go to ARM with the same `IDX`.
  - FIN: `DONE`=1, `BUSY`=0.
  - ERR: `ERROR`=1, `BUSY`=0, `IDX` frozen at the failing word.
- Failure path: increment the retry count and go to GAP. If the retry count already equals `MAX_RETRY`, go to ERR instead.
- `START` is latched on `CLOCK` into a pending flag.
  - In FIN or ERR, the next tick clears the flag and restarts the sequence as IDLE does.
  - In any other state, the pending flag is cleared and ignored.
- Timeouts use one shared tick counter, cleared on every state change.

## Timing
- Reset values:
  - `CTRL_CLK`=0, divider=0, `GO`=0, `I2C_DATA`=0, `BUSY`=0, `DONE`=0, `ERROR`=0, `IDX`=0.
  - FSM in IDLE, retry count 0, pending flag 0.
- Assertion of `RESET` mid-transaction drops `GO` and `CTRL_CLK` immediately (asynchronous). After release the full table reruns from word 0.
- `GO` and `I2C_DATA` change only on falling ticks. They are therefore stable for half a `CTRL_CLK` period before the controller's rising edge.
- `END` and `ACK` are sampled only on falling ticks, half a period after the controller updates them.
- `I2C_DATA` is held constant from ARM entry through CHECK.
- `GO` must not rise while `END`=0. GAP guarantees at least one low `GO` period, which returns the controller to its idle count.
- Nominal per-word cost is ARM + 33 periods + CHECK + GAP, about 36 `CTRL_CLK` periods. A clean 8-word run is about 290 periods.
- `DONE` and `ERROR` are never both 1.

## Structure
- Package `codec_cfg_pkg` holds:
  - the FSM state encoding;
  - register-word localparams (`WM_RESET`, `WM_PWR`, `WM_FMT`, `WM_SMP`, `WM_APATH`, `WM_DPATH`, `WM_HP`, `WM_ACT`);
  - default `SLAVE_ADDR`.
- Sub-module `codec_reg_rom`: combinational index → 16-bit word lookup. Out-of-range indices return 0x0000.
- Divider and FSM live in the top level.

## Test plan
- Nominal run: behavioural controller model, `CLK_DIV`=4, always ACKs → 8 `GO` pulses with `I2C_DATA` 0x341E00, 0x340C00, 0x340E42, 0x341000, 0x340812, 0x340A00, 0x340579, 0x341201. Then `DONE`=1, `BUSY`=0, `ERROR`=0.
- Single NACK: model returns `ACK`=1 once on word 2 → 0x340E42 is sent twice, the sequence completes, `DONE`=1, 9 `GO` pulses in total.
- Persistent NACK: word 5 always NACKs with `MAX_RETRY`=3 → 4 attempts of 0x340A00, then `ERROR`=1, `IDX`=5, `GO`=0 thereafter, `DONE`=0.
- Timeout: model holds `END`=1 and ignores `GO` → each attempt aborts after `TO_START` ticks. `ERROR`=1 after 4 attempts on word 0.
- Reset mid-transaction: assert `RESET` during word 3's WAIT_END → `GO`=0 and `CTRL_CLK`=0 immediately. After release, the sequence restarts at 0x341E00.
- `START` handling: `START` pulsed during the run is ignored (exactly 8 `GO` pulses). `START` pulsed after `DONE` clears `DONE` and repeats all 8 words.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer:
// FSM state encoding, codec register words and the default slave address.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_END,
    S_CHECK,
    S_GAP,
    S_FIN,
    S_ERR
  } state_e;

  localparam logic [15:0] WM_RESET = 16'h1E00;
  localparam logic [15:0] WM_PWR   = 16'h0C00;
  localparam logic [15:0] WM_FMT   = 16'h0E42;
  localparam logic [15:0] WM_SMP   = 16'h1000;
  localparam logic [15:0] WM_APATH = 16'h0812;
  localparam logic [15:0] WM_DPATH = 16'h0A00;
  localparam logic [15:0] WM_HP    = 16'h0579;
  localparam logic [15:0] WM_ACT   = 16'h1201;

  localparam logic [7:0] DEF_SLAVE_ADDR = 8'h34;

endpackage

// File: rtl/codec_reg_rom.sv
// Combinational codec register table: index -> 16-bit {sub addr, data}.
// Ports: idx_i table index, word_o word (0 for out-of-range indices).
module codec_reg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = 16'h0000;
    unique case (idx_i)
      4'd0:    word_o = WM_RESET;
      4'd1:    word_o = WM_PWR;
      4'd2:    word_o = WM_FMT;
      4'd3:    word_o = WM_SMP;
      4'd4:    word_o = WM_APATH;
      4'd5:    word_o = WM_DPATH;
      4'd6:    word_o = WM_HP;
      4'd7:    word_o = WM_ACT;
      default: word_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec register table into the I2C write engine with GO/END
// handshake, ACK check and retries; also generates the controller clock.
// Ports: CLOCK/RESET system, START rerun, CTRL_CLK slow clock, I2C_DATA/GO
// to controller, END/ACK from controller, BUSY/DONE/ERROR/IDX status.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int          CLK_DIV    = 1250,
  parameter logic [7:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int          NUM_REGS   = 8,
  parameter int          MAX_RETRY  = 3,
  parameter int          TO_START   = 4,
  parameter int          TO_END     = 40
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  output logic        CTRL_CLK,
  output logic [23:0] I2C_DATA,
  output logic        GO,
  input  logic        END,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  IDX
);

  localparam int DW = $clog2(CLK_DIV);

  state_e      state_q;
  logic [DW-1:0] div_q;
  logic        clk_q;
  logic        term;
  logic        tick;
  logic [7:0]  tmo_q;
  logic [3:0]  idx_q;
  logic [3:0]  retry_q;
  logic [3:0]  ld_idx;
  logic        ok_q;
  logic        pend_q;
  logic        go_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [23:0] data_q;
  logic [15:0] rom_word;
  logic        restart;
  logic        fail;
  logic        last;
  logic        parked;

  assign term = div_q == DW'(CLK_DIV - 1);
  // Tick only on the terminal count that drives CTRL_CLK low.
  assign tick = term && clk_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else if (term) begin
      div_q <= '0;
      clk_q <= ~clk_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign parked  = (state_q == S_FIN) || (state_q == S_ERR);
  assign restart = tick && ((state_q == S_IDLE) || (parked && pend_q));
  assign last    = idx_q == 4'(NUM_REGS - 1);

  // Index of the word loaded on the next ARM entry.
  always_comb begin
    ld_idx = idx_q;
    if (restart) ld_idx = '0;
    else if (state_q == S_GAP && ok_q) ld_idx = idx_q + 4'd1;
  end

  codec_reg_rom u_rom (
    .idx_i  (ld_idx),
    .word_o (rom_word)
  );

  always_comb begin
    fail = 1'b0;
    unique case (state_q)
      S_ARM:      fail = END && (tmo_q == 8'(TO_START - 1));
      S_WAIT_END: fail = !END && (tmo_q == 8'(TO_END - 1));
      S_CHECK:    fail = ACK;
      default:    fail = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      ok_q    <= 1'b0;
      pend_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      // Rerun requests only count once the sequence has parked.
      if (parked) pend_q <= restart ? 1'b0 : (pend_q | START);
      else pend_q <= 1'b0;

      if (restart) begin
        state_q <= S_ARM;
        tmo_q   <= '0;
        idx_q   <= '0;
        retry_q <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b1;
        go_q    <= 1'b1;
        data_q  <= {SLAVE_ADDR, rom_word};
      end else if (tick) begin
        unique case (state_q)
          S_ARM: begin
            if (!END) begin
              state_q <= S_WAIT_END;
              tmo_q   <= '0;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end
          S_WAIT_END: begin
            if (END) begin
              state_q <= S_CHECK;
              tmo_q   <= '0;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end
          S_CHECK: begin
            state_q <= S_GAP;
            ok_q    <= 1'b1;
            go_q    <= 1'b0;
            tmo_q   <= '0;
          end
          S_GAP: begin
            tmo_q <= '0;
            if (ok_q && last) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARM;
              go_q    <= 1'b1;
              data_q  <= {SLAVE_ADDR, rom_word};
              if (ok_q) begin
                idx_q   <= idx_q + 4'd1;
                retry_q <= '0;
              end
            end
          end
          default: ;
        endcase
        // Failure overrides the per-state updates above.
        if (fail) begin
          tmo_q <= '0;
          go_q  <= 1'b0;
          if (retry_q == 4'(MAX_RETRY)) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_GAP;
            retry_q <= retry_q + 4'd1;
            ok_q    <= 1'b0;
          end
        end
      end
    end
  end

  assign CTRL_CLK = clk_q;
  assign I2C_DATA = data_q;
  assign GO       = go_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = err_q;
  assign IDX      = idx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: behavioural I2C controller model,
// expected-attempt scoreboard and directed scenarios.
module tb_codec_config_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        END_r = 1'b1;
  logic        ACK_r = 1'b0;
  logic        CTRL_CLK;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [3:0]  IDX;

  always #5 CLOCK = ~CLOCK;

  codec_config_sequencer #(
    .CLK_DIV   (CLK_DIV),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .START    (START),
    .CTRL_CLK (CTRL_CLK),
    .I2C_DATA (I2C_DATA),
    .GO       (GO),
    .END      (END_r),
    .ACK      (ACK_r),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERROR    (ERROR),
    .IDX      (IDX)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  logic [15:0] tbl [8] = '{16'h1E00, 16'h0C00, 16'h0E42, 16'h1000,
                           16'h0812, 16'h0A00, 16'h0579, 16'h1201};

  // Controller model: starts on GO, holds END low 3 periods, then reports.
  bit          ctl_ignore = 0;
  logic [15:0] nack_val = 16'h0;
  int          nack_left = 0;
  int          c_state = 0;
  int          c_cnt = 0;
  bit          c_nack = 0;

  always @(posedge CTRL_CLK or negedge RESET) begin
    if (!RESET) begin
      c_state = 0;
      END_r <= 1'b1;
      ACK_r <= 1'b0;
    end else if (ctl_ignore) begin
      END_r <= 1'b1;
    end else begin
      case (c_state)
        0: if (GO) begin
          c_state = 1;
          c_cnt = 0;
          c_nack = (I2C_DATA[15:0] == nack_val) && (nack_left > 0);
          if (c_nack) nack_left--;
          END_r <= 1'b0;
          ACK_r <= 1'b0;
        end
        1: begin
          c_cnt++;
          if (c_cnt == 3) begin
            END_r <= 1'b1;
            ACK_r <= c_nack;
            c_state = 2;
          end
        end
        default: if (!GO) c_state = 0;
      endcase
    end
  end

  // Expected attempts from the table, retry budget and failure pattern.
  logic [23:0] exp_w[$];
  int          exp_i[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_idx;

  task automatic build(int nack_idx, int nack_n, bit tmo);
    int left;
    bit stop;
    bit ok;
    bit f;
    int retries;
    left = nack_n;
    stop = 0;
    exp_w.delete();
    exp_i.delete();
    exp_done = 0;
    exp_err = 0;
    exp_idx = 0;
    for (int i = 0; i < 8 && !stop; i++) begin
      retries = 0;
      ok = 0;
      while (!ok && !stop) begin
        exp_w.push_back({8'h34, tbl[i]});
        exp_i.push_back(i);
        f = tmo || (i == nack_idx && left > 0);
        if (i == nack_idx && left > 0) left--;
        if (!f) ok = 1;
        else if (retries == MAX_RETRY) begin
          stop = 1;
          exp_err = 1;
          exp_idx = i;
        end else retries++;
      end
    end
    if (!stop) begin
      exp_done = 1;
      exp_idx = 7;
    end
  endtask

  int          ptr = 0;
  logic [23:0] cap[$];
  logic        go_prev = 1'b0;

  always @(negedge CLOCK) begin
    if (!RESET) begin
      go_prev = 1'b0;
    end else begin
      check("done_error_excl", {31'd0, DONE & ERROR}, 32'd0);
      if (GO && !go_prev) begin
        cap.push_back(I2C_DATA);
        if (ptr >= exp_w.size()) begin
          check("unexpected_go", 32'd1, 32'd0);
        end else begin
          check("go_word", {8'd0, I2C_DATA}, {8'd0, exp_w[ptr]});
          check("go_idx", {28'd0, IDX}, exp_i[ptr]);
          check("go_end_high", {31'd0, END_r}, 32'd1);
          check("go_busy", {31'd0, BUSY}, 32'd1);
          ptr++;
        end
      end else if (GO && ptr > 0 && ptr <= exp_w.size()) begin
        check("data_stable", {8'd0, I2C_DATA}, {8'd0, exp_w[ptr-1]});
      end
      go_prev = GO;
    end
  end

  function automatic logic [23:0] capat(int i);
    return (i < cap.size()) ? cap[i] : 24'h0;
  endfunction

  task automatic wait_fin(string name);
    int n;
    n = 0;
    while (!(DONE || ERROR) && n < 20000) begin
      @(negedge CLOCK);
      n++;
    end
    check({name, "_finish_in_time"}, n, (n < 20000) ? n : 0);
  endtask

  task automatic check_end(string name);
    check({name, "_go_count"}, cap.size(), exp_w.size());
    check({name, "_done"}, {31'd0, DONE}, {31'd0, exp_done});
    check({name, "_error"}, {31'd0, ERROR}, {31'd0, exp_err});
    check({name, "_idx"}, {28'd0, IDX}, exp_idx);
    check({name, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({name, "_go_low"}, {31'd0, GO}, 32'd0);
  endtask

  task automatic do_reset(bit ign, logic [15:0] nv, int nl, int nidx, bit tmo);
    RESET = 1'b0;
    repeat (3) @(negedge CLOCK);
    ptr = 0;
    cap.delete();
    ctl_ignore = ign;
    nack_val = nv;
    nack_left = nl;
    build(nidx, nl, tmo);
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  task automatic wait_ptr(int n, string name);
    int k;
    k = 0;
    while (ptr < n && k < 20000) begin
      @(negedge CLOCK);
      k++;
    end
    check({name, "_reached"}, k, (k < 20000) ? k : 0);
  endtask

  initial begin
    int k;
    repeat (4) @(negedge CLOCK);
    check("rst_ctrl_clk", {31'd0, CTRL_CLK}, 32'd0);
    check("rst_go", {31'd0, GO}, 32'd0);
    check("rst_data", {8'd0, I2C_DATA}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_error", {31'd0, ERROR}, 32'd0);
    check("rst_idx", {28'd0, IDX}, 32'd0);

    // Nominal run, START pulsed mid-run must be ignored.
    do_reset(0, 16'h0, 0, -1, 0);
    wait_ptr(2, "nom_mid");
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    wait_fin("nom");
    check_end("nom");
    check("nom_w0", {8'd0, capat(0)}, 32'h341E00);
    check("nom_w2", {8'd0, capat(2)}, 32'h340E42);
    check("nom_w6", {8'd0, capat(6)}, 32'h340579);
    check("nom_w7", {8'd0, capat(7)}, 32'h341201);

    // START after DONE reruns all words.
    ptr = 0;
    cap.delete();
    build(-1, 0, 0);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (40) @(negedge CLOCK);
    check("rerun_done_cleared", {31'd0, DONE}, 32'd0);
    check("rerun_busy", {31'd0, BUSY}, 32'd1);
    wait_fin("rerun");
    check_end("rerun");
    check("rerun_w0", {8'd0, capat(0)}, 32'h341E00);

    // Single NACK on word 2.
    do_reset(0, 16'h0E42, 1, 2, 0);
    wait_fin("nack1");
    check_end("nack1");
    check("nack1_count", cap.size(), 32'd9);
    check("nack1_w2", {8'd0, capat(2)}, 32'h340E42);
    check("nack1_w3", {8'd0, capat(3)}, 32'h340E42);
    check("nack1_w8", {8'd0, capat(8)}, 32'h341201);

    // Persistent NACK on word 5.
    do_reset(0, 16'h0A00, 100, 5, 0);
    wait_fin("nackp");
    check_end("nackp");
    check("nackp_error", {31'd0, ERROR}, 32'd1);
    check("nackp_idx", {28'd0, IDX}, 32'd5);
    check("nackp_w5", {8'd0, capat(5)}, 32'h340A00);
    check("nackp_w8", {8'd0, capat(8)}, 32'h340A00);
    repeat (200) @(negedge CLOCK);
    check("nackp_go_quiet", {31'd0, GO}, 32'd0);
    check("nackp_count", cap.size(), 32'd9);

    // Controller ignores GO: start timeout on word 0.
    do_reset(1, 16'h0, 0, -1, 1);
    wait_fin("tmo");
    check_end("tmo");
    check("tmo_count", cap.size(), 32'd4);
    check("tmo_error", {31'd0, ERROR}, 32'd1);
    check("tmo_w3", {8'd0, capat(3)}, 32'h341E00);

    // Reset during word 3's WAIT_END.
    do_reset(0, 16'h0, 0, -1, 0);
    wait_ptr(4, "mid");
    k = 0;
    while (END_r && k < 2000) begin
      @(negedge CLOCK);
      k++;
    end
    check("mid_end_low", {31'd0, END_r}, 32'd0);
    repeat (6) @(negedge CLOCK);
    check("mid_word3", {8'd0, I2C_DATA}, 32'h341000);
    #2 RESET = 1'b0;
    #1;
    check("mid_go_drop", {31'd0, GO}, 32'd0);
    check("mid_clk_drop", {31'd0, CTRL_CLK}, 32'd0);
    do_reset(0, 16'h0, 0, -1, 0);
    wait_fin("after_rst");
    check_end("after_rst");
    check("after_rst_w0", {8'd0, capat(0)}, 32'h341E00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
